dmem_bus_arbiter: RTL and testbench

- Arbitrates the single-port 8-bit data memory bus between N_REQ requesters.
- Default owners: index 0 = debug/DMA port, 1 = stack unit, 2 = CPU load/store.
- Issues the per-requester grant, which the stack unit consumes as its bus_grant, and muxes the owner's address, write data and write strobe onto the memory.
- Supports locked multi-access sequences (e.g. push flags + PC) with a bounded lock length to prevent starvation.

---
 rtl/dmem_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter
// ----------------
// Arbitrates the single-port data memory bus between N_REQ requesters
// (0 = debug/DMA, 1 = stack unit, 2 = CPU load/store by default).
// The owner's address, write data and strobe are muxed onto the memory.
//
// Optional build macro: DMEM_ARB_ROUND_ROBIN_EN
//   undefined -> fixed priority, lowest index wins
//   defined   -> round-robin starting at (last_owner + 1) mod N_REQ
//
// Handshake: req[i] is the requester's valid. It is a level held until served.
// gnt[i] is the ready: exactly one memory access happens in each gnt cycle,
// using the requester's inputs in that same cycle. Read data on rdata must be
// taken in that cycle. Dropping req[i] during its gnt cycle cancels the access
// and releases the bus.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req, lock, wr    per-requester request / keep-bus / write-not-read
//   addr, wdata      packed per-requester address and write data
//   gnt              one-hot grant, decoded from the state flops
//   mem_addr, mem_dout, mem_wr, mem_rd   memory side of the bus
//   mem_din, rdata   memory read data, forwarded to all requesters
//   busy             bus owned this cycle
//   state_dbg        FSM state (0 = IDLE, 1 = OWNED)
module dmem_bus_arbiter #(
  parameter int N_REQ    = 3,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [N_REQ-1:0]   wr,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_dout,
  output logic               mem_wr,
  output logic               mem_rd,
  input  logic [DW-1:0]      mem_din,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic               state_dbg
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [CW-1:0]   lock_cnt, lock_cnt_n;
  logic [IW-1:0]   start, win;
  logic [N_REQ-1:0] own_mask, cand;
  logic            found, own_req, own_lock, at_max, hold, forced;
  int              j;

  // Owner decode and release conditions.
  always_comb begin
    own_mask        = '0;
    own_mask[owner] = 1'b1;
    own_req         = req[owner];
    own_lock        = lock[owner];
    at_max          = (lock_cnt == CW'(MAX_LOCK - 1));
    hold            = (state == OWNED) && own_req && own_lock && !at_max;
    forced          = (state == OWNED) && own_req && own_lock && at_max;
    // A releasing owner has just been served, so it does not compete for
    // the next cycle. A forced-release owner gets the bus back below only
    // when nobody else is waiting.
    cand            = (state == OWNED) ? (req & ~own_mask) : req;
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_owner;

  assign start = (last_owner == IW'(N_REQ - 1)) ? '0 : last_owner + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= IW'(N_REQ - 1);
    end else if (state_n == OWNED) begin
      last_owner <= owner_n;
    end
  end
`else
  assign start = '0;
`endif

  // Search starts at 'start' and wraps. In the fixed-priority build start is
  // 0, so this reduces to "lowest index wins".
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(start) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && cand[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_n    = IDLE;
    owner_n    = owner;
    lock_cnt_n = '0;
    if (hold) begin
      state_n    = OWNED;
      lock_cnt_n = lock_cnt + CW'(1);
    end else if (found) begin
      state_n = OWNED;
      owner_n = win;
    end else if (forced) begin
      // Nobody else waiting: same owner again, with a fresh lock budget.
      state_n = OWNED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  // Bus mux. Only the owner's slice is selected, so X on a non-owner's
  // inputs cannot reach memory. Outputs are held at zero while rst is high,
  // so no write from an abandoned locked sequence can land during reset.
  always_comb begin
    mem_addr = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    mem_rd   = 1'b0;
    if (state == OWNED && !rst) begin
      mem_addr = addr[int'(owner)*AW +: AW];
      mem_dout = wdata[int'(owner)*DW +: DW];
      mem_wr   = own_req & wr[owner];
      mem_rd   = own_req & ~wr[owner];
    end
  end

  assign gnt       = (state == OWNED) ? own_mask : '0;
  assign busy      = |gnt;
  assign rdata     = mem_din;
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Testbench for dmem_bus_arbiter: directed vectors, 256-byte memory model,
// expected bus cycles queued by the drivers and popped by a monitor whenever
// the DUT owns the bus.
module tb_dmem_bus_arbiter;

  localparam int EW = 45;  // {cycle[15:0], gnt[2:0], wr, rd, addr, dout, rdata}

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, lock, wr, gnt;
  logic [23:0] addr, wdata;
  logic [7:0]  mem_addr, mem_dout, mem_din, rdata;
  logic        mem_wr, mem_rd, busy, state_dbg;

  logic [7:0]  mem [256];
  logic        init_done = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e, mon_a;

  dmem_bus_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wr(wr),
    .addr(addr), .wdata(wdata), .gnt(gnt),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_din(mem_din), .rdata(rdata), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model: mem[i] = i ^ C3, mem[40] = 5A ----------------
  assign mem_din = mem[mem_addr];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
      mem[8'h40] <= 8'h5A;
      init_done  <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_dout;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                       input logic [23:0] a, input logic [23:0] d);
    @(posedge clk); #1;
    req = r; lock = l; wr = w; addr = a; wdata = d;
  endtask

  task automatic push(input int c, input logic [2:0] g, input logic w, input logic rd,
                      input logic [7:0] a, input logic [7:0] dout, input logic [7:0] rdat);
    logic [15:0] c16;
    c16 = c[15:0];
    exp_q.push_back({c16, g, w, rd, a, dout, rdat});
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; req = '0; lock = '0; wr = '0; addr = '0; wdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt",      64'(gnt),       64'h0);
    chk("rst_busy",     64'(busy),      64'h0);
    chk("rst_mem_addr", 64'(mem_addr),  64'h0);
    chk("rst_mem_dout", 64'(mem_dout),  64'h0);
    chk("rst_mem_wr",   64'(mem_wr),    64'h0);
    chk("rst_mem_rd",   64'(mem_rd),    64'h0);
    chk("rst_state",    64'(state_dbg), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Three readers at 10/20/30 all request; each drops req after its gnt cycle.
  task automatic prio_run(input int o0, input int o1, input int o2);
    int ord[3];
    logic [2:0] r;
    logic [7:0] a;
    ord = '{o0, o1, o2};
    r   = 3'b111;
    drive(r, 3'b000, 3'b000, 24'h302010, 24'h0);
    for (int k = 0; k < 3; k++) begin
      a = 8'((ord[k] + 1) * 16);
      push(cyc + 1, 3'(1 << ord[k]), 1'b0, 1'b1, a, 8'h00, a ^ 8'hC3);
      drive(r, 3'b000, 3'b000, 24'h302010, 24'h0);
      r[ord[k]] = 1'b0;
    end
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    @(negedge clk);
    chk("prio_idle_gnt", 64'(gnt), 64'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 64'(gnt), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = {cyc[15:0], gnt, mem_wr, mem_rd, mem_addr, mem_dout,
                 (mem_rd ? rdata : 8'h00)};
        chk("bus_cycle", 64'(mon_a), 64'(mon_e));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; req = '0; lock = '0; wr = '0; addr = '0; wdata = '0;

    // Single read by requester 2.
    do_reset;
    drive(3'b100, 3'b000, 3'b000, 24'h400000, 24'h0);
    push(cyc + 1, 3'b100, 1'b0, 1'b1, 8'h40, 8'h00, 8'h5A);
    drive(3'b100, 3'b000, 3'b000, 24'h400000, 24'h0);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    @(negedge clk);
    chk("read_release_gnt", 64'(gnt), 64'h0);

    // Locked push by stack unit while CPU waits; CPU follows with no bubble.
    do_reset;
    drive(3'b110, 3'b010, 3'b010, 24'h41FE00, 24'h001100);
    push(cyc + 1, 3'b010, 1'b1, 1'b0, 8'hFE, 8'h11, 8'h00);
    drive(3'b110, 3'b010, 3'b010, 24'h41FE00, 24'h001100);
    push(cyc + 1, 3'b010, 1'b1, 1'b0, 8'hFD, 8'h22, 8'h00);
    drive(3'b110, 3'b000, 3'b010, 24'h41FD00, 24'h002200);
    push(cyc + 1, 3'b100, 1'b0, 1'b1, 8'h41, 8'h00, 8'h82);
    drive(3'b100, 3'b000, 3'b000, 24'h41FD00, 24'h002200);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    @(negedge clk);
    chk("push_idle_gnt", 64'(gnt), 64'h0);
    chk("push_mem_fe",   64'(mem[8'hFE]), 64'h11);
    chk("push_mem_fd",   64'(mem[8'hFD]), 64'h22);

    // Priority order with three simultaneous requests.
    do_reset;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    drive(3'b001, 3'b000, 3'b000, 24'h000010, 24'h0);
    push(cyc + 1, 3'b001, 1'b0, 1'b1, 8'h10, 8'h00, 8'hD3);
    drive(3'b001, 3'b000, 3'b000, 24'h000010, 24'h0);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    prio_run(1, 2, 0);
`else
    prio_run(0, 1, 2);
`endif

    // Starvation guard: 4 locked cycles for 2, one for 0, back to 2,
    // then 2 drops req inside its gnt cycle (access suppressed).
    do_reset;
    drive(3'b100, 3'b100, 3'b100, 24'h500000, 24'h330000);
    for (int k = 0; k < 4; k++) begin
      push(cyc + 1, 3'b100, 1'b1, 1'b0, 8'h50, 8'h33, 8'h00);
      drive(3'b101, 3'b100, 3'b100, 24'h500010, 24'h330000);
    end
    push(cyc + 1, 3'b001, 1'b0, 1'b1, 8'h10, 8'h00, 8'hD3);
    drive(3'b101, 3'b100, 3'b100, 24'h500010, 24'h330000);
    push(cyc + 1, 3'b100, 1'b1, 1'b0, 8'h50, 8'h33, 8'h00);
    drive(3'b100, 3'b100, 3'b100, 24'h500000, 24'h330000);
    push(cyc + 1, 3'b100, 1'b0, 1'b0, 8'h50, 8'h33, 8'h00);
    drive(3'b000, 3'b000, 3'b100, 24'h500000, 24'h330000);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    @(negedge clk);
    chk("drop_idle_gnt",  64'(gnt),  64'h0);
    chk("drop_idle_busy", 64'(busy), 64'h0);
    chk("starve_mem_50",  64'(mem[8'h50]), 64'h33);

    // Reset in the second cycle of a locked stack write.
    do_reset;
    drive(3'b010, 3'b010, 3'b010, 24'h00E000, 24'h004400);
    push(cyc + 1, 3'b010, 1'b1, 1'b0, 8'hE0, 8'h44, 8'h00);
    drive(3'b010, 3'b010, 3'b010, 24'h00E000, 24'h004400);
    drive(3'b010, 3'b010, 3'b010, 24'h00E100, 24'h005500);
    rst = 1'b1;
    @(negedge clk);
    chk("rstlock_mem_wr", 64'(mem_wr), 64'h0);
    drive(3'b000, 3'b000, 3'b010, 24'h00E200, 24'h006600);
    rst = 1'b0;
    @(negedge clk);
    chk("rstlock_gnt",      64'(gnt),      64'h0);
    chk("rstlock_mem_wr2",  64'(mem_wr),   64'h0);
    chk("rstlock_mem_addr", 64'(mem_addr), 64'h0);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    @(negedge clk);
    chk("rstlock_mem_e0", 64'(mem[8'hE0]), 64'h44);
    chk("rstlock_mem_e1", 64'(mem[8'hE1]), 64'h22);
    chk("rstlock_mem_e2", 64'(mem[8'hE2]), 64'h21);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
